mux_scan_sequencer: RTL and testbench

Sequential driver and checker for the `mux_8x1` block. It latches an 8-bit word onto the mux data inputs `a`..`h` and steps the select lines `s0`,`s1`,`s2` through all eight codes. Each cycle it samples the mux output and rebuilds the word, then flags a mismatch when the rebuilt word differs from the latched one. It sits directly upstream of `mux_8x1`, because it produces every mux input, and directly downstream of it, because it consumes `returnVal`.

---
 rtl/mux_scan_sequencer.sv | 122 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Drives and checks a mux_8x1 block. It latches an 8-bit word onto the mux
//   data inputs and steps the selects through all eight codes. Each code is
//   held for HOLD_CYCLES cycles, and the mux output is sampled at the end of
//   that hold window. The sampled bits rebuild the word, which is then
//   compared against the latched word.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   single-cycle scan request, sampled only in IDLE
//   data_in   in   [7:0] word to scan (bit i -> mux input i)
//   mux_out   in   mux_8x1 returnVal
//   mux_in    out  [7:0] latched word driving mux inputs a..h
//   s0,s1,s2  out  mux selects, {s0,s1,s2} = index (s0 is the MSB)
//   busy      out  high in SCAN and DONE
//   done      out  one-cycle pulse in DONE
//   data_out  out  [7:0] rebuilt word
//   mismatch  out  data_out != mux_in, valid after DONE until next start/reset
module mux_scan_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       mux_out,
  output logic [7:0] mux_in,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  stateT      state;
  stateT      stateNext;
  logic [2:0] sel;
  logic [3:0] holdCnt;
  logic [7:0] muxInQ;
  logic [7:0] dataOutQ;
  logic       mismatchQ;
  logic       holdDone;

  assign holdDone = (holdCnt == HOLD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = SCAN;
      SCAN:    if (holdDone && (sel == 3'd7)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Index, hold counter and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= '0;
      holdCnt   <= '0;
      muxInQ    <= '0;
      dataOutQ  <= '0;
      mismatchQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            muxInQ    <= data_in;
            dataOutQ  <= '0;
            mismatchQ <= 1'b0;
            sel       <= '0;
            holdCnt   <= '0;
          end
        end
        SCAN: begin
          if (holdDone) begin
            dataOutQ[sel] <= mux_out;
            holdCnt       <= '0;
            // sel stays at 7 on the last code so DONE still selects h
            if (sel != 3'd7) sel <= sel + 3'd1;
          end else begin
            holdCnt <= holdCnt + 4'd1;
          end
        end
        DONE: begin
          mismatchQ <= (dataOutQ != muxInQ);
        end
        default: ;
      endcase
    end
  end

  // sel is already 7 throughout DONE, so it can drive the selects there as well
  assign {s0, s1, s2} = (state == IDLE) ? 3'b000 : sel;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign mux_in       = muxInQ;
  assign data_out     = dataOutQ;
  assign mismatch     = mismatchQ;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tbFault;

  // Instance with HOLD_CYCLES = 1
  logic       start1;
  logic [7:0] dataIn1;
  logic       muxOut1;
  logic [7:0] muxIn1;
  logic       s0a, s1a, s2a;
  logic       busy1, done1, mismatch1;
  logic [7:0] dataOut1;

  // Instance with HOLD_CYCLES = 3
  logic       start3;
  logic [7:0] dataIn3;
  logic       muxOut3;
  logic [7:0] muxIn3;
  logic       s0b, s1b, s2b;
  logic       busy3, done3, mismatch3;
  logic [7:0] dataOut3;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  // Behavioural mux_8x1. tbFault sticks the output at 0.
  assign muxOut1 = tbFault ? 1'b0 : muxIn1[{s0a, s1a, s2a}];
  assign muxOut3 = muxIn3[{s0b, s1b, s2b}];

  mux_scan_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .data_in(dataIn1),
    .mux_out(muxOut1), .mux_in(muxIn1), .s0(s0a), .s1(s1a), .s2(s2a),
    .busy(busy1), .done(done1), .data_out(dataOut1), .mismatch(mismatch1)
  );

  mux_scan_sequencer #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .data_in(dataIn3),
    .mux_out(muxOut3), .mux_in(muxIn3), .s0(s0b), .s1(s1b), .s2(s2b),
    .busy(busy3), .done(done3), .data_out(dataOut3), .mismatch(mismatch3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle1(input string tag, input logic [7:0] word);
    check({tag, "_busy"}, {7'd0, busy1}, 8'd0);
    check({tag, "_done"}, {7'd0, done1}, 8'd0);
    check({tag, "_sel"}, {5'd0, s0a, s1a, s2a}, 8'd0);
    check({tag, "_muxin"}, muxIn1, word);
    check({tag, "_dout"}, dataOut1, word);
    check({tag, "_mism"}, {7'd0, mismatch1}, 8'd0);
  endtask

  int doneCount;

  initial begin
    reset   = 1'b1;
    tbFault = 1'b0;
    start1  = 1'b1;
    start3  = 1'b1;
    dataIn1 = 8'hFF;
    dataIn3 = 8'hFF;

    // Reset held two cycles with start asserted
    tick();
    tick();
    checkIdle1("rst", 8'h00);
    check("rst_busy3", {7'd0, busy3}, 8'd0);
    check("rst_muxin3", muxIn3, 8'h00);
    reset  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    tick();
    check("rst_after_busy", {7'd0, busy1}, 8'd0);

    // Nominal scan, HOLD_CYCLES=1
    dataIn1 = 8'hA5;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    dataIn1 = 8'h00;
    check("nom_busy", {7'd0, busy1}, 8'd1);
    check("nom_muxin", muxIn1, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("nom_sel%0d", k), {5'd0, s0a, s1a, s2a}, 8'(k));
      check($sformatf("nom_nodone%0d", k), {7'd0, done1}, 8'd0);
      tick();
    end
    check("nom_done", {7'd0, done1}, 8'd1);
    check("nom_donesel", {5'd0, s0a, s1a, s2a}, 8'd7);
    check("nom_dout", dataOut1, 8'hA5);
    tick();
    checkIdle1("nom_idle", 8'hA5);
    tick();
    check("nom_stable", dataOut1, 8'hA5);

    // Hold window, HOLD_CYCLES=3
    dataIn3 = 8'h3C;
    start3  = 1'b1;
    tick();
    start3  = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("hold_sel%0d", k), {5'd0, s0b, s1b, s2b}, 8'(k / 3));
      check($sformatf("hold_nodone%0d", k), {7'd0, done3}, 8'd0);
      tick();
    end
    check("hold_done", {7'd0, done3}, 8'd1);
    check("hold_dout", dataOut3, 8'h3C);
    tick();
    check("hold_busy", {7'd0, busy3}, 8'd0);
    check("hold_mism", {7'd0, mismatch3}, 8'd0);

    // Fault detection: mux output stuck at 0
    tbFault = 1'b1;
    dataIn1 = 8'hFF;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("flt_done", {7'd0, done1}, 8'd1);
    check("flt_dout", dataOut1, 8'h00);
    check("flt_mism_early", {7'd0, mismatch1}, 8'd0);
    tick();
    check("flt_mism", {7'd0, mismatch1}, 8'd1);
    tick();
    check("flt_mism_held", {7'd0, mismatch1}, 8'd1);
    dataIn1 = 8'h00;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    check("flt2_mism_clr", {7'd0, mismatch1}, 8'd0);
    for (int k = 0; k < 8; k++) tick();
    check("flt2_done", {7'd0, done1}, 8'd1);
    tick();
    checkIdle1("flt2_idle", 8'h00);
    tbFault = 1'b0;

    // Start while busy is ignored
    dataIn1 = 8'h5A;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    tick();
    tick();
    tick();
    check("busy_sel3", {5'd0, s0a, s1a, s2a}, 8'd3);
    dataIn1 = 8'h00;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done1) doneCount++;
      tick();
    end
    check("busy_donecnt", 8'(doneCount), 8'd1);
    checkIdle1("busy_idle", 8'h5A);

    // Reset mid-scan
    dataIn1 = 8'hC3;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("mid_sel4", {5'd0, s0a, s1a, s2a}, 8'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkIdle1("mid_rst", 8'h00);
    tick();
    check("mid_stay", {7'd0, busy1}, 8'd0);
    dataIn1 = 8'h96;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("mid2_done", {7'd0, done1}, 8'd1);
    check("mid2_dout", dataOut1, 8'h96);
    tick();
    checkIdle1("mid2_idle", 8'h96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
